// File: rtl/ms_interval_timer.sv
// ----------------------------------------------------------------------------
// ms_interval_timer
//
// Programmable millisecond interval timer. It counts rising edges of the 1 ms
// tick from the clock divider and supports one-shot and auto-reload (periodic)
// operation. When an interval elapses, the timer raises a registered,
// single-cycle expire pulse. It also exposes the milliseconds remaining in the
// current interval.
//
// Optional build macro: MS_TIMER_EXPIRE_CNT_EN
//   defined   : expire_count is a saturating count of expire events. Only
//               reset clears it.
//   undefined : no counter register is built, and expire_count is tied to 0.
//
// Parameters
//   WIDTH  width of interval / remaining-count registers (max 2^WIDTH-1 ms)
//   CNT_W  width of the expire event counter
//
// Ports
//   clk          in   system clock (50 MHz); all state updates on posedge
//   reset        in   asynchronous, active-low; clears all state when 0
//   tick_1ms     in   1 ms tick; only its rising edge is counted
//   start        in   single-cycle request: load load_val and run
//   stop         in   single-cycle request: abort and return to IDLE
//   auto_reload  in   sampled with start; 1 = periodic, 0 = one-shot
//   load_val     in   interval in ms, sampled with start
//   busy         out  high while in RUN
//   expire       out  one-cycle pulse when the interval elapses
//   remaining    out  ms left in the current interval
//   expire_count out  saturating count of expire events (0 if not built)
// ----------------------------------------------------------------------------
module ms_interval_timer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1ms,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             expire,
  output logic [WIDTH-1:0] remaining,
  output logic [CNT_W-1:0] expire_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] reload_q,    reload_d;
  logic             mode_q,      mode_d;
  logic             expire_q,    expire_d;
  logic             tick_q;
  logic             tick_evt;

  // A tick held high for several cycles counts only once.
  assign tick_evt = tick_1ms & ~tick_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      mode_q      <= 1'b0;
      expire_q    <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      expire_q    <= expire_d;
      tick_q      <= tick_1ms;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: stop > start > tick_evt.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    mode_d      = mode_q;
    expire_d    = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else if (start) begin
      if (load_val != '0) begin
        // Any same-cycle tick is discarded. The new interval therefore
        // counts N full tick edges after this cycle.
        reload_d    = load_val;
        mode_d      = auto_reload;
        remaining_d = load_val;
        state_d     = ST_RUN;
      end else begin
        // A zero interval expires immediately and never reloads.
        expire_d    = 1'b1;
        remaining_d = '0;
        state_d     = ST_IDLE;
      end
    end else if (state_q == ST_RUN && tick_evt) begin
      if (remaining_q > WIDTH'(1)) begin
        remaining_d = remaining_q - WIDTH'(1);
      end else begin
        // Last millisecond of the interval. The comparison uses <= 1 rather
        // than == 1, so an unexpected zero count in RUN also terminates.
        expire_d = 1'b1;
        if (mode_q) begin
          remaining_d = reload_q;
        end else begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end
      end
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign expire    = expire_q;
  assign remaining = remaining_q;

  // --------------------------------------------------------------------------
  // Optional saturating expire counter. It increments on the same edge that
  // raises expire.
  // --------------------------------------------------------------------------
`ifdef MS_TIMER_EXPIRE_CNT_EN
  logic [CNT_W-1:0] expire_count_q, expire_count_d;

  always_comb begin
    expire_count_d = expire_count_q;
    if (expire_d && (expire_count_q != {CNT_W{1'b1}})) begin
      expire_count_d = expire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expire_count_q <= '0;
    end else begin
      expire_count_q <= expire_count_d;
    end
  end

  assign expire_count = expire_count_q;
`else
  assign expire_count = '0;
`endif

endmodule

// File: tb/tb_ms_interval_timer.sv
module tb_ms_interval_timer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick_1ms;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic             busy;
  logic             expire;
  logic [WIDTH-1:0] remaining;
  logic [CNT_W-1:0] expire_count;

  int checks = 0;
  int errors = 0;

  ms_interval_timer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1ms     (tick_1ms),
    .start        (start),
    .stop         (stop),
    .auto_reload  (auto_reload),
    .load_val     (load_val),
    .busy         (busy),
    .expire       (expire),
    .remaining    (remaining),
    .expire_count (expire_count)
  );

  always #5 clk = ~clk;

  // The expected counter value depends on whether the counter is built.
  function automatic logic [31:0] exp_cnt(input int n);
`ifdef MS_TIMER_EXPIRE_CNT_EN
    return (n > 255) ? 32'd255 : 32'(n);
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic e,
                         input logic [WIDTH-1:0] r, input int n);
    chk({tag, ".busy"},   32'(busy),         32'(b));
    chk({tag, ".expire"}, 32'(expire),       32'(e));
    chk({tag, ".rem"},    32'(remaining),    32'(r));
    chk({tag, ".cnt"},    32'(expire_count), exp_cnt(n));
    $display("step %-14s busy=%0d expire=%0d remaining=%0d count=%0d",
             tag, busy, expire, remaining, expire_count);
  endtask

  // Advance one clock edge and then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_tick();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
  endtask

  task automatic do_start(input logic [WIDTH-1:0] v, input logic ar);
    start = 1'b1; load_val = v; auto_reload = ar;
    step();
    start = 1'b0; load_val = '0; auto_reload = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick_1ms = 1'b0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; load_val = '0;
    idle(3);
    chk_all("reset", 1'b0, 1'b0, 16'd0, 0);
    reset = 1'b1;
    idle(2);
    chk_all("post_reset", 1'b0, 1'b0, 16'd0, 0);

    // One-shot interval of 3 ms.
    do_start(16'd3, 1'b0);
    chk_all("os_load", 1'b1, 1'b0, 16'd3, 0);
    idle(4);
    pulse_tick();
    chk_all("os_t1", 1'b1, 1'b0, 16'd2, 0);
    idle(4);
    pulse_tick();
    chk_all("os_t2", 1'b1, 1'b0, 16'd1, 0);
    idle(4);
    pulse_tick();
    chk_all("os_t3", 1'b0, 1'b1, 16'd0, 1);
    step();
    chk_all("os_after", 1'b0, 1'b0, 16'd0, 1);

    // Auto-reload with a 2 ms period.
    do_start(16'd2, 1'b1);
    chk_all("ar_load", 1'b1, 1'b0, 16'd2, 1);
    for (int k = 1; k <= 6; k++) begin
      idle(3);
      pulse_tick();
      chk_all($sformatf("ar_t%0d", k), 1'b1, (k % 2 == 0),
              (k % 2 == 0) ? 16'd2 : 16'd1, 1 + k / 2);
    end
    step();
    chk_all("ar_after", 1'b1, 1'b0, 16'd2, 4);

    // A stop request aborts the interval without an expire pulse.
    stop = 1'b1; step(); stop = 1'b0;
    chk_all("stop", 1'b0, 1'b0, 16'd0, 4);

    // A tick held high for 5 cycles counts once.
    do_start(16'd4, 1'b0);
    tick_1ms = 1'b1;
    idle(5);
    tick_1ms = 1'b0;
    step();
    chk_all("level_tick", 1'b1, 1'b0, 16'd3, 4);

    // A tick in the same cycle as start is discarded.
    start = 1'b1; load_val = 16'd7; tick_1ms = 1'b1;
    step();
    start = 1'b0; load_val = '0; tick_1ms = 1'b0;
    chk_all("start_tick", 1'b1, 1'b0, 16'd7, 4);
    step();
    chk_all("start_tick2", 1'b1, 1'b0, 16'd7, 4);

    // stop wins over start.
    stop = 1'b1; start = 1'b1; load_val = 16'd9;
    step();
    stop = 1'b0; start = 1'b0; load_val = '0;
    chk_all("stop_start", 1'b0, 1'b0, 16'd0, 4);

    // A zero interval expires immediately, even with auto_reload set.
    do_start(16'd0, 1'b1);
    chk_all("zero", 1'b0, 1'b1, 16'd0, 5);
    step();
    chk_all("zero_after", 1'b0, 1'b0, 16'd0, 5);

    // Restart in mid-run.
    do_start(16'd8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(2);
      pulse_tick();
    end
    chk_all("rs_mid", 1'b1, 1'b0, 16'd5, 5);
    do_start(16'd10, 1'b0);
    chk_all("restart", 1'b1, 1'b0, 16'd10, 5);
    step();
    chk_all("restart2", 1'b1, 1'b0, 16'd10, 5);

    // Ticks in IDLE are ignored.
    stop = 1'b1; step(); stop = 1'b0;
    pulse_tick();
    step();
    chk_all("idle_tick", 1'b0, 1'b0, 16'd0, 5);

    // Counter saturation: each cycle of start with load_val 0 expires once.
    start = 1'b1; load_val = 16'd0;
    idle(249);
    chk_all("sat_254", 1'b0, 1'b1, 16'd0, 254);
    step();
    chk_all("sat_255", 1'b0, 1'b1, 16'd0, 255);
    idle(10);
    chk_all("sat_hold", 1'b0, 1'b1, 16'd0, 265);
    start = 1'b0;
    step();
    chk_all("sat_end", 1'b0, 1'b0, 16'd0, 255);

    // Reset is asserted between clock edges in mid-run.
    do_start(16'd5, 1'b1);
    pulse_tick();
    chk_all("pre_rst", 1'b1, 1'b0, 16'd4, 255);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 16'd0, 0);
    step();
    reset = 1'b1;
    step();
    chk_all("rst_release", 1'b0, 1'b0, 16'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_interval_timer.md
Name: ms_interval_timer

Overview:
- Consumer of the 1 ms tick produced by the clock divider.
- Counts tick pulses to implement a programmable millisecond interval timer with one-shot or auto-reload modes.
- Emits a single-cycle expire pulse and exposes the remaining count.
- Used for CPU-visible delays, display refresh intervals and timeouts, all clocked from the 50 MHz system clock.

Parameters:
- WIDTH, 16, width of the interval and remaining-count registers (max interval 2^WIDTH-1 ms).
- CNT_W, 8, width of the expire event counter.

Ports:
- clk  input  1  system clock, 50 MHz, all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state when 0.
- tick_1ms  input  1  tick from the divider; only the rising edge is counted.
- start  input  1  single-cycle request: load load_val and run.
- stop  input  1  single-cycle request: abort and return to IDLE.
- auto_reload  input  1  sampled with start; 1 = periodic, 0 = one-shot.
- load_val  input  WIDTH  interval in ms, sampled with start.
- busy  output  1  high while in RUN.
- expire  output  1  one-cycle pulse when the interval elapses.
- remaining  output  WIDTH  ms left in the current interval.
- expire_count  output  CNT_W  saturating count of expire events.

Behaviour:
- Reset (async, reset==0): state=IDLE; busy=0, expire=0, remaining=0, expire_count=0; reload register=0, reload-mode flag=0, tick_d=0.
- Tick detection: tick_d is a register copy of tick_1ms. tick_evt = tick_1ms & ~tick_d (combinational). A tick held high for k cycles counts once.
- States: IDLE, RUN. busy is 1 exactly in RUN.
- Priority in every cycle: stop > start > tick_evt.
- stop: state->IDLE, remaining->0, no expire pulse, expire_count unchanged. Allowed in IDLE, where it has no effect.
- start with load_val!=0 (IDLE or RUN):
  - reload register<=load_val, mode flag<=auto_reload, remaining<=load_val, state->RUN.
  - A same-cycle tick_evt is discarded.
  - Restart while running is legal.
- start with load_val==0:
  - expire=1 the next cycle, expire_count increments, state->IDLE, remaining=0.
  - No reload, even when auto_reload=1.
- RUN with tick_evt and remaining>1: remaining<=remaining-1.
- RUN with tick_evt and remaining==1:
  - expire=1 for exactly the next cycle; expire_count increments, saturating at 2^CNT_W-1.
  - Mode flag=1: remaining<=reload register, stay in RUN.
  - Mode flag=0: remaining<=0, state->IDLE.
- Latency: expire is registered. Its high cycle immediately follows the clock edge at which the final tick rising edge is sampled.
- Interval accuracy:
  - N ms interval = N tick rising edges after the start cycle.
  - The first interval may be short by up to 1 ms (tick phase is arbitrary).
  - Auto-reload periods are exactly N ticks.
- tick_evt in IDLE: ignored (tick_d still updates).
- Reset asserted mid-RUN: immediate clear to reset values; no expire pulse.
- Inputs are synchronous to clk; no internal synchronisers.

Optional Feature:
- Macro: MS_TIMER_EXPIRE_CNT_EN.
- Defined: expire_count register implemented as specified (saturating, cleared only by reset).
- Undefined: no counter register is built; expire_count is tied to constant 0. All other behaviour is identical.

Test Plan:
- One-shot: reset, start=1 with load_val=3, auto_reload=0, then 3 tick pulses 50000 cycles apart -> remaining 3,2,1,0; expire high exactly one cycle after the 3rd tick; busy falls on the same edge; expire_count=1.
- Auto-reload: load_val=2, auto_reload=1, 6 ticks -> expire pulses after ticks 2, 4 and 6; remaining cycles 2,1,2,1,2,1; busy stays 1; expire_count=3.
- Level tick and priority:
  - tick_1ms held high 5 cycles with load_val=4 -> remaining decrements once (4->3).
  - start and tick together with load_val=7 -> remaining=7.
  - stop and start together -> IDLE, remaining=0.
- Zero / restart:
  - start with load_val=0 -> one expire pulse next cycle, busy stays 0.
  - start(10) mid-run at remaining=5 -> remaining=10, no expire pulse.
- Saturation and reset:
  - With CNT_W=8, force 260 expires -> expire_count=255.
  - Assert reset mid-RUN (asynchronous, between clock edges) -> all outputs 0 immediately.
  - Rebuild without MS_TIMER_EXPIRE_CNT_EN -> expire_count constantly 0.
